// File: rtl/alu_rs_sched_pkg.sv
// Shared sizes and opcode/optype encodings for the integer-ALU reservation station.
package alu_rs_sched_pkg;

    localparam int ROB_SZ_LOG = 4;
    localparam int DEF_RS_SZ  = 16;

    typedef enum logic [3:0] {
        OPT_CAL  = 4'd0,
        OPT_CALI = 4'd1,
        OPT_BRA  = 4'd2,
        OPT_JUM  = 4'd3
    } optype_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLL  = 4'd2,  OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,  OP_XOR  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
        OP_OR   = 4'd8,  OP_AND  = 4'd9,  OP_BEQ  = 4'd10, OP_BNE  = 4'd11,
        OP_BLT  = 4'd12, OP_BGE  = 4'd13, OP_BLTU = 4'd14, OP_BGEU = 4'd15
    } opcode_e;

endpackage

// File: rtl/alu_rs_pick.sv
// Combinational issue selector: lowest-index ready entry, or the oldest ready entry
// via the age matrix when ALU_RS_AGE_SEL_EN is defined.
module alu_rs_pick #(
    parameter int N     = 16,
    parameter int N_LOG = $clog2(N)
) (
    input  logic [N-1:0]          i_ready,
`ifdef ALU_RS_AGE_SEL_EN
    input  logic [N-1:0][N-1:0]   i_age,
`endif
    output logic                  o_found,
    output logic [N_LOG-1:0]      o_idx
);

    logic [N-1:0] w_cand;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_cand = '0;
`ifdef ALU_RS_AGE_SEL_EN
        for (int i = 0; i < N; i++)
            w_cand[i] = i_ready[i] & ~|(i_age[i] & i_ready);
`else
        w_cand = i_ready;
`endif
    end

    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (w_cand[i]) o_idx = N_LOG'(i);
    end

    assign o_found = |i_ready;

endmodule

// File: rtl/alu_rs_sched.sv
// ALU reservation station: buffers dispatched ALU ops, snoops two CDBs, issues one ready
// entry per cycle on a registered port. Define ALU_RS_AGE_SEL_EN for oldest-first select.
module alu_rs_sched
    import alu_rs_sched_pkg::*;
#(
    parameter int RS_SZ = DEF_RS_SZ,
    parameter int TAG_W = ROB_SZ_LOG + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clr_in,
    input  logic             disp_flg,
    input  logic [TAG_W-1:0] disp_rd,
    input  logic [31:0]      disp_Vj,
    input  logic [31:0]      disp_Vk,
    input  logic             disp_Qj_flg,
    input  logic             disp_Qk_flg,
    input  logic [TAG_W-1:0] disp_Qj,
    input  logic [TAG_W-1:0] disp_Qk,
    input  logic [31:0]      disp_imm,
    input  logic [31:0]      disp_pc,
    input  logic [3:0]       disp_opcode,
    input  logic [3:0]       disp_optype,
    input  logic             cdb0_flg,
    input  logic [TAG_W-1:0] cdb0_rd,
    input  logic [31:0]      cdb0_val,
    input  logic             cdb1_flg,
    input  logic [TAG_W-1:0] cdb1_rd,
    input  logic [31:0]      cdb1_val,
    output logic             full,
    output logic             run_flg,
    output logic [TAG_W-1:0] rd_fr,
    output logic [31:0]      Vj,
    output logic [31:0]      Vk,
    output logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic [3:0]       opcode,
    output logic [3:0]       optype
);

    localparam int RS_SZ_LOG = $clog2(RS_SZ);

    logic [RS_SZ-1:0] r_busy, r_qj_flg, r_qk_flg;
    logic [TAG_W-1:0] r_rd [RS_SZ];
    logic [TAG_W-1:0] r_qj [RS_SZ];
    logic [TAG_W-1:0] r_qk [RS_SZ];
    logic [31:0]      r_vj [RS_SZ];
    logic [31:0]      r_vk [RS_SZ];
    logic [31:0]      r_imm [RS_SZ];
    logic [31:0]      r_pc [RS_SZ];
    logic [3:0]       r_opcode [RS_SZ];
    logic [3:0]       r_optype [RS_SZ];

    logic             r_run_flg;
    logic [TAG_W-1:0] r_iss_rd;
    logic [31:0]      r_iss_vj, r_iss_vk, r_iss_imm, r_iss_pc;
    logic [3:0]       r_iss_opcode, r_iss_optype;

    logic [RS_SZ-1:0]     w_ready;
    logic                 w_found, w_step, w_disp_ok;
    logic [RS_SZ_LOG-1:0] w_pick, w_free_idx;
    logic                 w_dj_flg, w_dk_flg;
    logic [31:0]          w_dj_val, w_dk_val;

    // Operand wake-up against both buses; cdb0 takes precedence on a double match.
    function automatic logic [32:0] resolve(input logic pend, input logic [TAG_W-1:0] q,
                                            input logic [31:0] v);
        if (pend && cdb0_flg && cdb0_rd == q) return {1'b0, cdb0_val};
        if (pend && cdb1_flg && cdb1_rd == q) return {1'b0, cdb1_val};
        return {pend, v};
    endfunction

    assign w_ready   = r_busy & ~r_qj_flg & ~r_qk_flg;
    assign full      = &r_busy;
    assign w_step    = rdy_in & ~rst_in & ~clr_in;
    assign w_disp_ok = disp_flg & ~full;

    always_comb begin
        w_free_idx = '0;
        for (int i = RS_SZ - 1; i >= 0; i--)
            if (!r_busy[i]) w_free_idx = RS_SZ_LOG'(i);
    end

    always_comb begin
        {w_dj_flg, w_dj_val} = resolve(disp_Qj_flg, disp_Qj, disp_Vj);
        {w_dk_flg, w_dk_val} = resolve(disp_Qk_flg, disp_Qk, disp_Vk);
    end

`ifdef ALU_RS_AGE_SEL_EN
    // r_age[i][j] set means entry j is older than entry i; a reused slot clears its column.
    logic [RS_SZ-1:0][RS_SZ-1:0] r_age;

    always_ff @(posedge clk_in) begin
        if (w_step && w_disp_ok) begin
            for (int i = 0; i < RS_SZ; i++) r_age[i][w_free_idx] <= 1'b0;
            r_age[w_free_idx] <= r_busy;
        end
    end
`endif

    alu_rs_pick #(.N(RS_SZ), .N_LOG(RS_SZ_LOG)) u_pick (
        .i_ready (w_ready),
`ifdef ALU_RS_AGE_SEL_EN
        .i_age   (r_age),
`endif
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // NOTE: entry payload is not reset; busy gates every use, so only control state needs it.
    always_ff @(posedge clk_in) begin
        if (w_step) begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (r_busy[i]) begin
                    {r_qj_flg[i], r_vj[i]} <= resolve(r_qj_flg[i], r_qj[i], r_vj[i]);
                    {r_qk_flg[i], r_vk[i]} <= resolve(r_qk_flg[i], r_qk[i], r_vk[i]);
                end
            end
            if (w_disp_ok) begin
                r_rd[w_free_idx]     <= disp_rd;
                r_qj[w_free_idx]     <= disp_Qj;
                r_qk[w_free_idx]     <= disp_Qk;
                r_qj_flg[w_free_idx] <= w_dj_flg;
                r_qk_flg[w_free_idx] <= w_dk_flg;
                r_vj[w_free_idx]     <= w_dj_val;
                r_vk[w_free_idx]     <= w_dk_val;
                r_imm[w_free_idx]    <= disp_imm;
                r_pc[w_free_idx]     <= disp_pc;
                r_opcode[w_free_idx] <= disp_opcode;
                r_optype[w_free_idx] <= disp_optype;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy       <= '0;
            r_run_flg    <= 1'b0;
            r_iss_rd     <= '0;
            r_iss_vj     <= '0;
            r_iss_vk     <= '0;
            r_iss_imm    <= '0;
            r_iss_pc     <= '0;
            r_iss_opcode <= '0;
            r_iss_optype <= '0;
        end else if (clr_in) begin
            r_busy    <= '0;
            r_run_flg <= 1'b0;
        end else if (rdy_in) begin
            r_run_flg <= w_found;
            if (w_found) begin
                r_busy[w_pick] <= 1'b0;
                r_iss_rd       <= r_rd[w_pick];
                r_iss_vj       <= r_vj[w_pick];
                r_iss_vk       <= r_vk[w_pick];
                r_iss_imm      <= r_imm[w_pick];
                r_iss_pc       <= r_pc[w_pick];
                r_iss_opcode   <= r_opcode[w_pick];
                r_iss_optype   <= r_optype[w_pick];
            end
            if (w_disp_ok) r_busy[w_free_idx] <= 1'b1;
        end
    end

    assign run_flg = r_run_flg;
    assign rd_fr   = r_iss_rd;
    assign Vj      = r_iss_vj;
    assign Vk      = r_iss_vk;
    assign imm     = r_iss_imm;
    assign pc      = r_iss_pc;
    assign opcode  = r_iss_opcode;
    assign optype  = r_iss_optype;

endmodule

// File: tb/tb_alu_rs_sched.sv
// Scoreboard bench for alu_rs_sched: directed test-plan scenarios plus randomized traffic
// checked against a slot/sequence-number reference model.
module tb_alu_rs_sched;
    import alu_rs_sched_pkg::*;

    localparam int N  = DEF_RS_SZ;
    localparam int TW = ROB_SZ_LOG + 1;

`ifdef ALU_RS_AGE_SEL_EN
    localparam logic [31:0] FIRST_RD = 32'd15, SECOND_RD = 32'd20;
`else
    localparam logic [31:0] FIRST_RD = 32'd20, SECOND_RD = 32'd15;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, clr_in;
    logic          disp_flg, disp_Qj_flg, disp_Qk_flg;
    logic [TW-1:0] disp_rd, disp_Qj, disp_Qk;
    logic [31:0]   disp_Vj, disp_Vk, disp_imm, disp_pc;
    logic [3:0]    disp_opcode, disp_optype;
    logic          cdb0_flg, cdb1_flg;
    logic [TW-1:0] cdb0_rd, cdb1_rd;
    logic [31:0]   cdb0_val, cdb1_val;
    logic          full, run_flg;
    logic [TW-1:0] rd_fr;
    logic [31:0]   Vj, Vk, imm, pc;
    logic [3:0]    opcode, optype;

    always #5 clk_in = ~clk_in;

    alu_rs_sched dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .disp_flg(disp_flg), .disp_rd(disp_rd), .disp_Vj(disp_Vj), .disp_Vk(disp_Vk),
        .disp_Qj_flg(disp_Qj_flg), .disp_Qk_flg(disp_Qk_flg), .disp_Qj(disp_Qj), .disp_Qk(disp_Qk),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_opcode(disp_opcode), .disp_optype(disp_optype),
        .cdb0_flg(cdb0_flg), .cdb0_rd(cdb0_rd), .cdb0_val(cdb0_val),
        .cdb1_flg(cdb1_flg), .cdb1_rd(cdb1_rd), .cdb1_val(cdb1_val),
        .full(full), .run_flg(run_flg), .rd_fr(rd_fr), .Vj(Vj), .Vk(Vk), .imm(imm), .pc(pc),
        .opcode(opcode), .optype(optype)
    );

    typedef struct {
        int            edge_n;
        logic [TW-1:0] rd;
        logic [31:0]   vj, vk, imm, pc;
        logic [3:0]    opc, opt;
    } iss_t;

    iss_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_cnt = 0;

    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    // Reference model: one record per slot, age kept as a dispatch sequence number.
    logic          m_busy [N];
    logic          m_jf [N], m_kf [N];
    logic [TW-1:0] m_rd [N], m_qj [N], m_qk [N];
    logic [31:0]   m_vj [N], m_vk [N], m_imm [N], m_pc [N];
    logic [3:0]    m_opc [N], m_opt [N];
    int            m_seq [N];
    int            seq_n = 0;
    logic          m_run = 1'b0;
    iss_t          m_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] resolve(input logic pend, input logic [TW-1:0] q,
                                            input logic [31:0] v);
        if (pend && cdb0_flg && cdb0_rd == q) return {1'b0, cdb0_val};
        if (pend && cdb1_flg && cdb1_rd == q) return {1'b0, cdb1_val};
        return {pend, v};
    endfunction

    function automatic logic model_full();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        m_run = 1'b0;
    endtask

    // Effect of the upcoming clock edge, given the inputs currently driven.
    task automatic model_step();
        int pick, free_s;
        if (rst_in || clr_in) begin
            model_clear();
            return;
        end
        if (!rdy_in) begin
            if (m_run) begin
                m_out.edge_n = edge_cnt + 1;
                exp_q.push_back(m_out);
            end
            return;
        end
        pick   = -1;
        free_s = -1;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && !m_jf[i] && !m_kf[i]) begin
`ifdef ALU_RS_AGE_SEL_EN
                if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
            if (!m_busy[i] && free_s < 0) free_s = i;
        end
        m_run = (pick >= 0);
        if (pick >= 0) begin
            m_out.edge_n = edge_cnt + 1;
            m_out.rd  = m_rd[pick];  m_out.vj = m_vj[pick]; m_out.vk  = m_vk[pick];
            m_out.imm = m_imm[pick]; m_out.pc = m_pc[pick]; m_out.opc = m_opc[pick];
            m_out.opt = m_opt[pick];
            exp_q.push_back(m_out);
            m_busy[pick] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) begin
                {m_jf[i], m_vj[i]} = resolve(m_jf[i], m_qj[i], m_vj[i]);
                {m_kf[i], m_vk[i]} = resolve(m_kf[i], m_qk[i], m_vk[i]);
            end
        end
        if (disp_flg && free_s >= 0) begin
            m_busy[free_s] = 1'b1;
            m_rd[free_s]   = disp_rd;
            m_qj[free_s]   = disp_Qj;
            m_qk[free_s]   = disp_Qk;
            {m_jf[free_s], m_vj[free_s]} = resolve(disp_Qj_flg, disp_Qj, disp_Vj);
            {m_kf[free_s], m_vk[free_s]} = resolve(disp_Qk_flg, disp_Qk, disp_Vk);
            m_imm[free_s]  = disp_imm;
            m_pc[free_s]   = disp_pc;
            m_opc[free_s]  = disp_opcode;
            m_opt[free_s]  = disp_optype;
            m_seq[free_s]  = seq_n;
            seq_n++;
        end
    endtask

    // Monitor: every edge, match the issue port against the expected-issue queue.
    initial begin
        iss_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (run_flg === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL issue@%0d: got unexpected issue rd=%0d Vj=%h, expected none",
                             edge_cnt, rd_fr, Vj);
                end else begin
                    e = exp_q.pop_front();
                    if (e.edge_n != edge_cnt || rd_fr !== e.rd || Vj !== e.vj || Vk !== e.vk ||
                        imm !== e.imm || pc !== e.pc || opcode !== e.opc || optype !== e.opt) begin
                        n_errors++;
                        $display("FAIL issue@%0d: got rd=%0d Vj=%h Vk=%h imm=%h pc=%h op=%0d/%0d, expected edge=%0d rd=%0d Vj=%h Vk=%h imm=%h pc=%h op=%0d/%0d",
                                 edge_cnt, rd_fr, Vj, Vk, imm, pc, opcode, optype,
                                 e.edge_n, e.rd, e.vj, e.vk, e.imm, e.pc, e.opc, e.opt);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_n <= edge_cnt) begin
                n_checks++;
                n_errors++;
                e = exp_q.pop_front();
                $display("FAIL issue@%0d: got run_flg=%b, expected issue of rd=%0d", edge_cnt,
                         run_flg, e.rd);
            end
        end
    end

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
        disp_flg = 1'b0; cdb0_flg = 1'b0; cdb1_flg = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        @(negedge clk_in);
        check("full", 32'(full), 32'(model_full()));
    endtask

    task automatic dispatch(input int rd, input logic qjf, input int qj, input logic [31:0] vj,
                            input logic qkf, input int qk, input logic [31:0] vk,
                            input logic [3:0] opc);
        disp_flg    = 1'b1;
        disp_rd     = TW'(rd);
        disp_Qj_flg = qjf; disp_Qj = TW'(qj); disp_Vj = vj;
        disp_Qk_flg = qkf; disp_Qk = TW'(qk); disp_Vk = vk;
        disp_opcode = opc;
        disp_optype = 4'($urandom_range(0, 3));
        disp_imm    = $urandom;
        disp_pc     = $urandom;
    endtask

    task automatic cdb(input int bus, input int rd, input logic [31:0] val);
        if (bus == 0) begin
            cdb0_flg = 1'b1; cdb0_rd = TW'(rd); cdb0_val = val;
        end else begin
            cdb1_flg = 1'b1; cdb1_rd = TW'(rd); cdb1_val = val;
        end
    endtask

    initial begin
        idle();
        dispatch(0, 1'b0, 0, 0, 1'b0, 0, 0, OP_ADD);
        disp_flg = 1'b0;
        cdb0_rd = '0; cdb0_val = '0; cdb1_rd = '0; cdb1_val = '0;
        rst_in = 1'b1;
        tick();
        tick();
        idle();
        check("rst_run_flg", 32'(run_flg), 32'd0);
        check("rst_rd_fr", 32'(rd_fr), 32'd0);
        check("rst_vj", Vj, 32'd0);
        check("rst_vk", Vk, 32'd0);
        check("rst_imm_pc", imm | pc, 32'd0);
        check("rst_op", 32'({opcode, optype}), 32'd0);

        // Minimum latency: both operands ready.
        dispatch(3, 1'b0, 0, 32'd5, 1'b0, 0, 32'd7, OP_ADD);
        tick(); idle(); tick();
        check("add_run_flg", 32'(run_flg), 32'd1);
        check("add_rd_fr", 32'(rd_fr), 32'd3);
        check("add_vj", Vj, 32'd5);
        check("add_vk", Vk, 32'd7);
        check("add_opcode", 32'(opcode), 32'(OP_ADD));

        // Wake-up through cdb1.
        dispatch(6, 1'b1, 9, 32'hDEAD, 1'b0, 0, 32'd2, OP_SUB);
        tick(); idle(); tick();
        cdb(1, 9, 32'h100);
        tick(); idle(); tick();
        check("sub_run_flg", 32'(run_flg), 32'd1);
        check("sub_vj", Vj, 32'h100);

        // Dispatch bypass from cdb0 in the same cycle.
        dispatch(7, 1'b0, 0, 32'd1, 1'b1, 4, 32'd0, OP_AND);
        cdb(0, 4, 32'hFFFF_FFFF);
        tick(); idle(); tick();
        check("byp_run_flg", 32'(run_flg), 32'd1);
        check("byp_vk", Vk, 32'hFFFF_FFFF);

        // Fill, drop on full, then free entry 0.
        for (int i = 0; i < N; i++) begin
            dispatch(i, 1'b1, 16 + i, 32'd0, 1'b0, 0, 32'(i), OP_OR);
            tick();
        end
        idle();
        check("fill_full", 32'(full), 32'd1);
        dispatch(31, 1'b0, 0, 32'd9, 1'b0, 0, 32'd9, OP_XOR);
        tick(); idle();
        check("drop_full", 32'(full), 32'd1);
        cdb(0, 16, 32'h1234);
        tick(); idle(); tick();
        check("wake0_full", 32'(full), 32'd0);
        check("wake0_rd", 32'(rd_fr), 32'd0);
        clr_in = 1'b1;
        tick(); idle();

        // Priority: slot 5 older than a re-filled slot 2.
        for (int i = 0; i < 6; i++) begin
            dispatch(10 + i, 1'b1, i, 32'd0, 1'b0, 0, 32'd0, OP_SLT);
            tick();
        end
        idle(); cdb(0, 2, 32'h22);
        tick(); idle(); tick();
        dispatch(20, 1'b1, 8, 32'd0, 1'b0, 0, 32'd0, OP_SRL);
        tick(); idle();
        cdb(0, 8, 32'h88); cdb(1, 5, 32'h55);
        tick(); idle(); tick();
        check("age_first", 32'(rd_fr), FIRST_RD);
        tick();
        check("age_second", 32'(rd_fr), SECOND_RD);

        // Flush with 6 busy entries and a simultaneous dispatch.
        dispatch(21, 1'b1, 12, 32'd0, 1'b0, 0, 32'd0, OP_ADD); tick();
        dispatch(22, 1'b1, 13, 32'd0, 1'b0, 0, 32'd0, OP_ADD); tick();
        dispatch(23, 1'b0, 0, 32'd1, 1'b0, 0, 32'd1, OP_ADD);
        clr_in = 1'b1;
        tick(); idle();
        check("clr_full", 32'(full), 32'd0);
        check("clr_run_flg", 32'(run_flg), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cdb(0, 2 * i, 32'd0); cdb(1, (2 * i + 1 == 7) ? 12 : 2 * i + 1, 32'd0);
            tick(); idle();
            check("clr_quiet", 32'(run_flg), 32'd0);
        end
        cdb(0, 13, 32'd0);
        tick(); idle(); tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            idle();
            rdy_in = ($urandom_range(0, 7) != 0);
            clr_in = ($urandom_range(0, 199) == 0);
            rst_in = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 2) != 0)
                dispatch($urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                         $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
                         4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) != 0) cdb(0, $urandom_range(0, 7), $urandom);
            if ($urandom_range(0, 2) == 0) cdb(1, $urandom_range(0, 7), $urandom);
            tick();
        end

        // Drain: resolve every random tag, then let the station empty.
        idle();
        for (int k = 0; k < 4; k++) begin
            cdb(0, 2 * k, $urandom); cdb(1, 2 * k + 1, $urandom);
            tick(); idle();
        end
        for (int k = 0; k < N + 4; k++) tick();
        check("drain_full", 32'(full), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_rs_sched.md
# alu_rs_sched

Reservation-station scheduler for the integer ALU in the out-of-order core. It buffers dispatched ALU-class instructions (CAL, CALi, BRA, JUM) until both operands are resolved, snoops the two CDB buses for tagged results, and issues one ready entry per cycle to the ALU through registered inputs. It sits between the decoder/dispatch stage and the combinational ALU; ALU results return to the ROB and CDB.

## Interface
- `RS_SZ`, default 16: entry count, power of 2; `RS_SZ_LOG` = log2(`RS_SZ`).
- `TAG_W`, default `ROB_SZ_LOG`+1: ROB tag width.
- `clk_in` in 1: sole clock, rising edge.
- `rst_in` in 1: reset, synchronous and active-high.
- `rdy_in` in 1: global enable; when low, all state and outputs hold.
- `clr_in` in 1: misprediction flush.
- `disp_flg` in 1: dispatch valid.
- `disp_rd` in TAG_W: destination ROB tag.
- `disp_Vj`, `disp_Vk` in 32: operand values, meaningful when the matching Q flag is 0.
- `disp_Qj_flg`, `disp_Qk_flg` in 1: operand pending.
- `disp_Qj`, `disp_Qk` in TAG_W: producer tags.
- `disp_imm`, `disp_pc` in 32; `disp_opcode`, `disp_optype` in 4.
- `cdb0_flg`, `cdb1_flg` in 1; `cdb0_rd`, `cdb1_rd` in TAG_W; `cdb0_val`, `cdb1_val` in 32: result broadcasts.
- `full` out 1: no free entry.
- `run_flg` out 1; `rd_fr` out TAG_W; `Vj`, `Vk`, `imm`, `pc` out 32; `opcode`, `optype` out 4: ALU issue port, all registered.

## Operation
- Entry state: busy, rd, Vj/Qj/Qj_flg, Vk/Qk/Qk_flg, imm, pc, opcode, optype. Ready = busy & !Qj_flg & !Qk_flg.
- Dispatch: when `disp_flg` and !`full`, write the lowest-index free entry. If `disp_flg` is asserted while `full`, the dispatch is dropped and no state changes.
- Dispatch bypass: if a pending dispatch operand tag matches a valid CDB tag in the same cycle, store the CDB value and clear the Q flag.
- Snoop: for every busy entry with Qx_flg set and Qx equal to a valid cdbN_rd, latch cdbN_val and clear the flag. If both buses match, cdb0 wins; the values are identical by construction.
- Select: among entries that are ready at the start of the cycle, pick one. Issue registers its fields onto the ALU port, drives `run_flg`=1, and clears busy. If no entry is ready, `run_flg`=0 and the other outputs hold.
- Flush (`clr_in`): clear all busy bits and drive `run_flg`=0 at the next edge. A dispatch in the same cycle is ignored. Flush has priority over dispatch and issue.
- `full` = occupancy == RS_SZ, taken from registered state. An entry freed by an issue in cycle t becomes available to dispatch in cycle t+1.
- Reset: all busy=0, `full`=0, `run_flg`=0, all other outputs 0.

## Timing
- Minimum latency: dispatch with both operands ready in cycle t → entry valid at edge t+1 → selected in t+1 → `run_flg`=1 in cycle t+2.
- An operand woken by the CDB in cycle t makes its entry eligible for select in t+1.
- Issue throughput is one per cycle. Dispatch and issue may occur in the same cycle.
- `rdy_in`=0 freezes everything, including `run_flg`. Reset and flush take effect regardless of `rdy_in`.
- A flush or reset asserted mid-stream discards all entries. No entry issues after the edge on which the flush is taken.

## Configuration
- `ALU_RS_AGE_SEL_EN` defined: oldest-first selection using an RS_SZ×RS_SZ age matrix. On dispatch, set the new entry's row to mark all current busy entries as older. Select the ready entry with no older ready entry.
- `ALU_RS_AGE_SEL_EN` undefined: lowest-index ready entry wins; the age matrix is not built.

## Structure
- `def.v` holds `ROB_SZ_LOG`, `RS_SZ`, `RS_SZ_LOG`, the optype codes (`CAL`, `CALi`, `BRA`, `JUM`), and the opcode macros.
- Sub-module `alu_rs_pick`: combinational selector taking the ready vector and, when `ALU_RS_AGE_SEL_EN` is defined, the age matrix. It outputs a found flag and an index.

## Test plan
- Dispatch ADD, rd=3, Vj=5, Vk=7, both ready, in cycle 0 → cycle 2: `run_flg`=1, `rd_fr`=3, `Vj`=5, `Vk`=7, `opcode`=ADD.
- Dispatch SUB with Qj_flg=1, Qj=9; cdb1 broadcasts rd=9, val=0x100 in cycle 4 → issue in cycle 6 with `Vj`=0x100.
- Dispatch with Qk=4 while cdb0 broadcasts rd=4, val=0xFFFF_FFFF in the same cycle → entry is ready immediately; `Vk`=0xFFFF_FFFF at issue.
- Fill 16 entries with pending tags → `full`=1. A 17th dispatch is dropped. Wake entry 0 → `full`=0 the cycle after its issue.
- Entries in slots 5 (older) and 2 (younger) wake in the same cycle → with `ALU_RS_AGE_SEL_EN` defined, slot 5 issues first; without it, slot 2 issues first.
- Hold 6 busy entries, assert `clr_in` together with a dispatch → next cycle `full`=0, `run_flg`=0, and nothing issues afterwards.
